ham_max_engine: RTL and testbench

Hardware search engine that sits downstream of the data memory and consumes the operand block stored there. It reads COUNT bytes starting at BASE and finds the maximum pairwise Hamming distance over all unordered pairs. It writes that maximum back to RESULT_ADDR and raises Halt. It computes in one pass the value the software program leaves at mem[127], and doubles as the hardware golden model for the operand-search labs.

---
 rtl/ham_max_pkg.sv | 15 +
 rtl/ham_dist8.sv | 12 +
 rtl/ham_max_engine.sv | 126 ++++++++++++
 tb/tb_ham_max_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ham_max_pkg.sv
// Shared types and helpers for the maximum pairwise Hamming distance engine.
package ham_max_pkg;

  localparam int HAM_W = 4;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

  function automatic logic [HAM_W-1:0] popcount8(input logic [7:0] v);
    logic [HAM_W-1:0] n;
    n = '0;
    for (int k = 0; k < 8; k++) n = n + HAM_W'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/ham_dist8.sv
// Combinational Hamming distance between two bytes.
module ham_dist8
  import ham_max_pkg::*;
(
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [HAM_W-1:0] d
);

  assign d = popcount8(a ^ b);

endmodule

// File: rtl/ham_max_engine.sv
// Loads COUNT operand bytes, scans every unordered pair for the largest
// Hamming distance, writes it to RESULT_ADDR and halts.
module ham_max_engine
  import ham_max_pkg::*;
#(
  parameter logic [7:0] BASE        = 8'd128,
  parameter int         COUNT       = 20,
  parameter logic [7:0] RESULT_ADDR = 8'd127
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  output logic [7:0]       mem_addr,
  input  logic [7:0]       mem_rd_data,
  output logic             mem_wr_en,
  output logic [7:0]       mem_wr_data,
  output logic             busy,
  output logic             Halt,
  output logic [HAM_W-1:0] ham_max,
  output logic [7:0]       idx_i,
  output logic [7:0]       idx_j
);

  localparam logic [5:0] LD_END = 6'(COUNT);
  localparam logic [4:0] LAST_I = 5'(COUNT - 2);
  localparam logic [4:0] LAST_J = 5'(COUNT - 1);

  state_t           state;
  logic [7:0]       buf_q [COUNT];
  logic [5:0]       ld_cnt;
  logic [5:0]       ld_nxt;
  logic [4:0]       i_q, j_q;
  logic [HAM_W-1:0] d;
  logic [HAM_W-1:0] max_nxt;
  logic             hit;

  ham_dist8 u_dist (
    .a (buf_q[i_q]),
    .b (buf_q[j_q]),
    .d (d)
  );

  // Strict compare: a tie never displaces the earlier pair.
  assign hit     = d > ham_max;
  assign max_nxt = hit ? d : ham_max;
  assign ld_nxt  = ld_cnt + 6'd1;

  // NOTE: the operand buffer is plain storage that is always fully reloaded
  // before use, so it has no reset and stays out of the async-reset block.
  always_ff @(posedge CLK) begin
    if (state == LOAD && ld_cnt != 6'd0) buf_q[5'(ld_cnt - 6'd1)] <= mem_rd_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      Halt        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= 8'd0;
      mem_wr_data <= 8'd0;
      ham_max     <= '0;
      idx_i       <= 8'd0;
      idx_j       <= 8'd0;
      ld_cnt      <= 6'd0;
      i_q         <= 5'd0;
      j_q         <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            Halt     <= 1'b0;
            ham_max  <= '0;
            idx_i    <= BASE;
            idx_j    <= BASE;
            ld_cnt   <= 6'd0;
            mem_addr <= BASE;
          end
        end
        LOAD: begin
          // ld_cnt is the index on the bus; its read data lands one cycle later.
          ld_cnt   <= ld_nxt;
          mem_addr <= (ld_nxt < LD_END) ? BASE + 8'(ld_nxt) : 8'd0;
          if (ld_cnt == LD_END) begin
            state <= SCAN;
            i_q   <= 5'd0;
            j_q   <= 5'd1;
          end
        end
        SCAN: begin
          if (hit) begin
            ham_max <= d;
            idx_i   <= BASE + 8'(i_q);
            idx_j   <= BASE + 8'(j_q);
          end
          if (j_q == LAST_J) begin
            if (i_q == LAST_I) begin
              state       <= WRITE;
              mem_wr_en   <= 1'b1;
              mem_addr    <= RESULT_ADDR;
              mem_wr_data <= {{(8 - HAM_W){1'b0}}, max_nxt};
            end else begin
              i_q <= i_q + 5'd1;
              j_q <= i_q + 5'd2;
            end
          end else begin
            j_q <= j_q + 5'd1;
          end
        end
        WRITE: begin
          state     <= DONE;
          mem_wr_en <= 1'b0;
          mem_addr  <= 8'd0;
          busy      <= 1'b0;
          Halt      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ham_max_engine.sv
// Scoreboard bench for ham_max_engine with a synchronous-read memory model.
module tb_ham_max_engine;

  localparam int BASE_A = 128;
  localparam int NOPS   = 20;
  localparam int LAT    = 212;

  typedef struct {
    int hmax;
    int ii;
    int jj;
  } exp_t;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = 8'd0;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       Halt;
  logic [3:0] ham_max;
  logic [7:0] idx_i, idx_j;

  logic [7:0] mem [256];
  int         wr_count = 0;
  logic [7:0] wr_addr_log = 8'd0;
  logic [7:0] wr_data_log = 8'd0;

  logic [7:0] hd_a, hd_b;
  logic [3:0] hd_d;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  ham_max_engine dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .Halt        (Halt),
    .ham_max     (ham_max),
    .idx_i       (idx_i),
    .idx_j       (idx_j)
  );

  ham_dist8 u_hd (.a(hd_a), .b(hd_b), .d(hd_d));

  always @(posedge CLK) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en === 1'b1) begin
      wr_count    <= wr_count + 1;
      wr_addr_log <= mem_addr;
      wr_data_log <= mem_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pc8(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(v[k]);
    return n;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.hmax = 0;
    e.ii   = BASE_A;
    e.jj   = BASE_A;
    for (int i = 0; i < NOPS - 1; i++)
      for (int j = i + 1; j < NOPS; j++)
        if (pc8(mem[BASE_A + i] ^ mem[BASE_A + j]) > e.hmax) begin
          e.hmax = pc8(mem[BASE_A + i] ^ mem[BASE_A + j]);
          e.ii   = BASE_A + i;
          e.jj   = BASE_A + j;
        end
    sb.push_back(e);
  endtask

  task automatic fill_ops(input logic [7:0] v);
    for (int k = 0; k < NOPS; k++) mem[BASE_A + k] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halt"}, Halt, 0);
    check({tag, "_wr_en"}, mem_wr_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wr_data"}, mem_wr_data, 0);
    check({tag, "_ham_max"}, ham_max, 0);
    check({tag, "_idx_i"}, idx_i, 0);
    check({tag, "_idx_j"}, idx_j, 0);
  endtask

  task automatic run_and_check(input string name, input bit hold_start);
    exp_t e;
    int   edges = 0;
    int   busy_cyc;
    int   overlap = 0;
    int   wr0;
    push_expected();
    wr0 = wr_count;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    check({name, "_accept_halt"}, Halt, 0);
    busy_cyc = busy ? 1 : 0;
    if (!hold_start) start = 1'b0;
    while (Halt !== 1'b1 && edges < 1000) begin
      @(posedge CLK);
      #1;
      edges++;
      if (busy) busy_cyc++;
      if (busy && Halt) overlap++;
    end
    start = 1'b0;
    check({name, "_halt_edge"}, edges, LAT);
    check({name, "_busy_cycles"}, busy_cyc, LAT);
    check({name, "_busy_halt_overlap"}, overlap, 0);
    e = sb.pop_front();
    check({name, "_ham_max"}, ham_max, e.hmax);
    check({name, "_idx_i"}, idx_i, e.ii);
    check({name, "_idx_j"}, idx_j, e.jj);
    check({name, "_writes"}, wr_count - wr0, 1);
    check({name, "_wr_addr"}, wr_addr_log, 127);
    check({name, "_wr_data"}, wr_data_log, e.hmax);
  endtask

  initial begin
    int wr_before;
    Reset_n = 1'b0;
    start   = 1'b0;
    hd_a    = 8'd0;
    hd_b    = 8'd0;
    for (int k = 0; k < 256; k++) mem[k] = 8'd0;

    for (int k = 0; k < 6; k++) begin
      hd_a = 8'($urandom);
      hd_b = (k == 0) ? ~hd_a : 8'($urandom);
      #1;
      check("ham_dist8", hd_d, pc8(hd_a ^ hd_b));
    end

    #12;
    check_reset_vals("reset");
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_start_busy", busy, 0);

    fill_ops(8'h00);
    run_and_check("zeros", 1'b0);

    fill_ops(8'h00);
    mem[135] = 8'h12;
    mem[140] = 8'hED;
    run_and_check("ff_pair", 1'b0);

    fill_ops(8'h00);
    mem[128] = 8'h24;
    mem[129] = 8'h81;
    mem[130] = 8'h0F;
    mem[131] = 8'h0F;
    run_and_check("tie", 1'b0);

    for (int k = 0; k < NOPS; k++) mem[BASE_A + k] = 8'($urandom);
    run_and_check("random", 1'b0);

    // Abort in the middle of SCAN; no write must reach the memory.
    for (int k = 0; k < NOPS; k++) mem[BASE_A + k] = 8'($urandom);
    wr_before = wr_count;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (100) @(posedge CLK);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    check("abort_no_write", wr_count, wr_before);
    run_and_check("after_abort", 1'b0);

    for (int k = 0; k < NOPS; k++) mem[BASE_A + k] = 8'($urandom);
    run_and_check("held_start", 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    check("halt_stays", Halt, 1);
    check("halt_stays_busy", busy, 0);

    fill_ops(8'h00);
    mem[147] = 8'h3C;
    mem[133] = 8'hC3;
    run_and_check("restart", 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
